// File: rtl/bridge_16_32_pkg.sv
// Shared definitions for the 16->32 upsizing bridge: state encoding and
// the byte-lane steering helper used when a 16-bit access lands on a 32-bit bus.
package bridge_16_32_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUS   = 2'd1;
  localparam logic [1:0] ST_COMPL = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    BUS   = ST_BUS,
    COMPL = ST_COMPL
  } state_t;

  // Place a 2-bit host byte select onto the upper or lower half of a 4-lane bus.
  function automatic logic [3:0] lane_steer(input logic hi_half, input logic [1:0] sel);
    return hi_half ? {sel, 2'b00} : {2'b00, sel};
  endfunction

endpackage

// File: rtl/bridge_16_32_if.sv
// Host-side (16-bit) and bus-side (32-bit) signal bundle of the upsizing bridge.
// The bridge uses the slave view; whatever drives host requests and answers bus cycles uses master.
interface bridge_16_32_if;

  logic        h_cs;
  logic [31:0] h_addr;
  logic [15:0] h_wdata;
  logic [15:0] h_rdata;
  logic        h_wr_en;
  logic [1:0]  h_bytesel;
  logic        h_compl;
  logic        inv;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic [31:0] b_rdata;
  logic        b_wr_en;
  logic [3:0]  b_bytesel;
  logic        b_compl;

  modport slave (
    input  h_cs, h_addr, h_wdata, h_wr_en, h_bytesel, inv, b_rdata, b_compl,
    output h_rdata, h_compl, b_addr, b_wdata, b_wr_en, b_bytesel
  );

  modport master (
    output h_cs, h_addr, h_wdata, h_wr_en, h_bytesel, inv, b_rdata, b_compl,
    input  h_rdata, h_compl, b_addr, b_wdata, b_wr_en, b_bytesel
  );

endinterface

// File: rtl/bridge_16_32_hold.sv
// One-word read hold register: remembers the last fetched 32-bit bus word so
// the other halfword of it can be returned without a bus access.
module bridge_16_32_hold (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fill,
  input  logic [29:0] fill_addr,
  input  logic [31:0] fill_data,
  input  logic        clear,
  input  logic [29:0] cmp_addr,
  output logic        match,
  output logic [31:0] data
);

  logic        valid_q;
  logic [29:0] addr_q;
  logic [31:0] data_q;

  // Clear takes priority so an invalidate arriving with a fill leaves nothing cached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (fill) begin
      valid_q <= 1'b1;
      addr_q  <= fill_addr;
      data_q  <= fill_data;
    end
  end

  always_comb begin
    match = valid_q && (addr_q == cmp_addr);
    data  = data_q;
  end

endmodule

// File: rtl/bridge_16_32.sv
// Upsizing bridge: turns 16-bit host reads/writes into 32-bit bus transfers,
// steering byte lanes by h_addr[1], with an optional one-word read hold register.
module bridge_16_32
  import bridge_16_32_pkg::*;
#(
  parameter bit HOLD_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  bridge_16_32_if.slave bif
);

  state_t      state;
  state_t      state_nx;

  logic        req;
  logic        hit;
  logic        idle_req;
  logic        bus_done;
  logic        hold_match;
  logic [31:0] hold_data;
  logic        hold_fill;
  logic        hold_clear;
  logic        unused_addr_bit;

  logic [29:0] b_word_q;
  logic [31:0] b_wdata_q;
  logic        b_wr_q;
  logic [3:0]  b_sel_q;
  logic        half_q;
  logic        inv_seen_q;
  logic [15:0] h_rdata_q;

  assign unused_addr_bit = bif.h_addr[0];

  assign req      = bif.h_cs && (|bif.h_bytesel);
  assign idle_req = (state == IDLE) && req;
  assign hit      = HOLD_EN && !bif.h_wr_en && hold_match && !bif.inv;
  assign bus_done = (state == BUS) && bif.b_compl;

  // A fill is skipped if inv was seen at any point while this read was on the bus.
  assign hold_fill  = bus_done && !b_wr_q && HOLD_EN && !inv_seen_q;
  assign hold_clear = bif.inv || (idle_req && bif.h_wr_en);

  bridge_16_32_hold u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .fill      (hold_fill),
    .fill_addr (b_word_q),
    .fill_data (bif.b_rdata),
    .clear     (hold_clear),
    .cmp_addr  (bif.h_addr[31:2]),
    .match     (hold_match),
    .data      (hold_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (req) begin
          state_nx = hit ? COMPL : BUS;
        end
      end
      BUS: begin
        if (bif.b_compl) begin
          state_nx = COMPL;
        end
      end
      COMPL:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The request is withdrawn combinationally in the completion cycle itself.
  always_comb begin
    bif.h_compl   = (state == COMPL);
    bif.b_bytesel = ((state == BUS) && !bif.b_compl) ? b_sel_q : 4'b0000;
  end

  assign bif.h_rdata = h_rdata_q;
  assign bif.b_addr  = {b_word_q, 2'b00};
  assign bif.b_wdata = b_wdata_q;
  assign bif.b_wr_en = b_wr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_word_q   <= '0;
      b_wdata_q  <= '0;
      b_wr_q     <= 1'b0;
      b_sel_q    <= 4'b0000;
      half_q     <= 1'b0;
      inv_seen_q <= 1'b0;
      h_rdata_q  <= '0;
    end else begin
      if (idle_req) begin
        half_q     <= bif.h_addr[1];
        inv_seen_q <= 1'b0;
        if (hit) begin
          h_rdata_q <= bif.h_addr[1] ? hold_data[31:16] : hold_data[15:0];
        end else begin
          b_word_q  <= bif.h_addr[31:2];
          b_wdata_q <= {bif.h_wdata, bif.h_wdata};
          b_wr_q    <= bif.h_wr_en;
          // Reads fetch the whole word when it can be kept for the other half.
          b_sel_q   <= (!bif.h_wr_en && HOLD_EN) ? 4'b1111
                                                 : lane_steer(bif.h_addr[1], bif.h_bytesel);
        end
      end
      if (state == BUS) begin
        if (bif.inv) begin
          inv_seen_q <= 1'b1;
        end
        if (bif.b_compl) begin
          b_sel_q <= 4'b0000;
          if (!b_wr_q) begin
            h_rdata_q <= half_q ? bif.b_rdata[31:16] : bif.b_rdata[15:0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bridge_16_32.sv
// Scoreboard bench for bridge_16_32: two instances (hold enabled / disabled),
// a bus responder checking each bus request, and a host monitor checking each completion.
module tb_bridge_16_32;

  typedef struct {
    logic [15:0] rdata;
    int          issue;
    int          lat;
  } host_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [3:0]  sel;
  } bus_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic        h_cs = 1'b0;
  logic [31:0] h_addr = '0;
  logic [15:0] h_wdata = '0;
  logic        h_wr_en = 1'b0;
  logic [1:0]  h_bytesel = 2'b00;
  logic        inv_v = 1'b0;
  int          tgt = 0;
  logic [31:0] b_rdata_v [2];
  logic        b_compl_v [2];

  int          bus_lat = 2;
  logic [31:0] bus_data = '0;
  bit          inv_on_compl = 1'b0;

  host_exp_t   host_q[$];
  bus_exp_t    bus_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  logic [3:0]  b_sel_w   [2];
  logic [31:0] b_addr_w  [2];
  logic [31:0] b_wdata_w [2];
  logic        b_wr_w    [2];
  logic        h_compl_w [2];
  logic [15:0] h_rdata_w [2];

  bridge_16_32_if bif0 ();
  bridge_16_32_if bif1 ();

  bridge_16_32 #(.HOLD_EN(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bif(bif0.slave));
  bridge_16_32 #(.HOLD_EN(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bif(bif1.slave));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign bif0.h_cs      = h_cs && (tgt == 0);
  assign bif1.h_cs      = h_cs && (tgt == 1);
  assign bif0.h_addr    = h_addr;
  assign bif1.h_addr    = h_addr;
  assign bif0.h_wdata   = h_wdata;
  assign bif1.h_wdata   = h_wdata;
  assign bif0.h_wr_en   = h_wr_en;
  assign bif1.h_wr_en   = h_wr_en;
  assign bif0.h_bytesel = h_bytesel;
  assign bif1.h_bytesel = h_bytesel;
  assign bif0.inv       = inv_v && (tgt == 0);
  assign bif1.inv       = inv_v && (tgt == 1);
  assign bif0.b_rdata   = b_rdata_v[0];
  assign bif1.b_rdata   = b_rdata_v[1];
  assign bif0.b_compl   = b_compl_v[0];
  assign bif1.b_compl   = b_compl_v[1];

  assign b_sel_w[0]   = bif0.b_bytesel;
  assign b_sel_w[1]   = bif1.b_bytesel;
  assign b_addr_w[0]  = bif0.b_addr;
  assign b_addr_w[1]  = bif1.b_addr;
  assign b_wdata_w[0] = bif0.b_wdata;
  assign b_wdata_w[1] = bif1.b_wdata;
  assign b_wr_w[0]    = bif0.b_wr_en;
  assign b_wr_w[1]    = bif1.b_wr_en;
  assign h_compl_w[0] = bif0.h_compl;
  assign h_compl_w[1] = bif1.h_compl;
  assign h_rdata_w[0] = bif0.h_rdata;
  assign h_rdata_w[1] = bif1.h_rdata;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one host access, queue its expected completion (and bus request), wait for h_compl.
  task automatic applyStimulus(input int t, input logic [31:0] a, input logic wr,
                               input logic [15:0] wd, input logic [1:0] sel,
                               input logic [15:0] exp_rd, input int exp_lat,
                               input bit bus_req, input logic [3:0] exp_bsel);
    host_exp_t he;
    bus_exp_t  be;
    bit        seen;
    @(negedge clk);
    he.rdata = exp_rd;
    he.issue = cyc;
    he.lat   = exp_lat;
    host_q.push_back(he);
    if (bus_req) begin
      be.addr  = {a[31:2], 2'b00};
      be.wdata = {wd, wd};
      be.wr    = wr;
      be.sel   = exp_bsel;
      bus_q.push_back(be);
    end
    tgt       = t;
    h_addr    = a;
    h_wr_en   = wr;
    h_wdata   = wd;
    h_bytesel = sel;
    h_cs      = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (h_compl_w[t]) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL compl_timeout: got no h_compl for addr 0x%0h, expected one", a);
    end
    h_cs      = 1'b0;
    h_bytesel = 2'b00;
    h_wr_en   = 1'b0;
  endtask

  // Bus responder: checks each new request, answers after bus_lat cycles.
  initial begin
    int cnt [2];
    bit raised [2];
    cnt = '{0, 0};
    b_compl_v = '{1'b0, 1'b0};
    b_rdata_v = '{32'h0, 32'h0};
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        raised[k] = 1'b0;
        if (!rst_n) begin
          cnt[k] = 0;
          b_compl_v[k] = 1'b0;
        end else if (b_compl_v[k]) begin
          b_compl_v[k] = 1'b0;
          inv_v = 1'b0;
        end else if (b_sel_w[k] != 4'b0000) begin
          cnt[k]++;
          if (cnt[k] == 1) begin
            if (bus_q.size() == 0) begin
              total++;
              bad++;
              $display("[TB] FAIL bus_unexpected: got bytesel 0x%0h, expected no request", b_sel_w[k]);
            end else begin
              bus_exp_t e;
              e = bus_q.pop_front();
              checkOutput("b_addr", b_addr_w[k], e.addr);
              checkOutput("b_wdata", b_wdata_w[k], e.wdata);
              checkOutput("b_wr_en", {31'b0, b_wr_w[k]}, {31'b0, e.wr});
              checkOutput("b_bytesel", {28'b0, b_sel_w[k]}, {28'b0, e.sel});
            end
          end
          if (cnt[k] >= bus_lat) begin
            b_rdata_v[k] = bus_data;
            b_compl_v[k] = 1'b1;
            cnt[k] = 0;
            raised[k] = 1'b1;
            if (inv_on_compl) inv_v = 1'b1;
          end
        end
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        if (raised[k]) checkOutput("bsel_drop", {28'b0, b_sel_w[k]}, 32'h0);
      end
    end
  end

  // Host monitor: every h_compl pops one expectation and checks data and latency.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (h_compl_w[k]) begin
          if (host_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL h_compl_unexpected: got h_compl on dut%0d, expected none", k);
          end else begin
            host_exp_t e;
            e = host_q.pop_front();
            checkOutput("h_rdata", {16'b0, h_rdata_w[k]}, {16'b0, e.rdata});
            checkOutput("latency", cyc - e.issue, e.lat);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_h_rdata", {16'b0, bif0.h_rdata}, 32'h0);
    checkOutput("rst_h_compl", {31'b0, bif0.h_compl}, 32'h0);
    checkOutput("rst_b_addr", bif0.b_addr, 32'h0);
    checkOutput("rst_b_wdata", bif0.b_wdata, 32'h0);
    checkOutput("rst_b_wr_en", {31'b0, bif0.b_wr_en}, 32'h0);
    checkOutput("rst_b_bytesel", {28'b0, bif1.b_bytesel}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Read miss fetches the full word; other half then hits the hold register.
    bus_data = 32'hAAAA5555;
    applyStimulus(0, 32'h100, 1'b0, 16'h0000, 2'b11, 16'h5555, 3, 1'b1, 4'b1111);
    applyStimulus(0, 32'h102, 1'b0, 16'h0000, 2'b11, 16'hAAAA, 1, 1'b0, 4'b0000);

    // Chip select with no byte enables is not a request.
    @(negedge clk);
    tgt = 0; h_addr = 32'h100; h_bytesel = 2'b00; h_cs = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("nosel_bytesel", {28'b0, bif0.b_bytesel}, 32'h0);
    checkOutput("nosel_h_compl", {31'b0, bif0.h_compl}, 32'h0);
    h_cs = 1'b0;

    // Write steers to the upper half and invalidates the hold register.
    applyStimulus(0, 32'h206, 1'b1, 16'h1234, 2'b01, 16'hAAAA, 3, 1'b1, 4'b0100);
    applyStimulus(0, 32'h102, 1'b0, 16'h0000, 2'b11, 16'hAAAA, 3, 1'b1, 4'b1111);

    // inv coincident with the fill: data returned but not cached.
    bus_data = 32'h13579BDF;
    inv_on_compl = 1'b1;
    applyStimulus(0, 32'h300, 1'b0, 16'h0000, 2'b11, 16'h9BDF, 3, 1'b1, 4'b1111);
    inv_on_compl = 1'b0;
    applyStimulus(0, 32'h302, 1'b0, 16'h0000, 2'b11, 16'h1357, 3, 1'b1, 4'b1111);

    // Reset while the bus cycle is outstanding.
    @(negedge clk);
    begin
      bus_exp_t be;
      be.addr = 32'h400; be.wdata = 32'hBEEFBEEF; be.wr = 1'b0; be.sel = 4'b1111;
      bus_q.push_back(be);
    end
    bus_lat = 20;
    tgt = 0; h_addr = 32'h400; h_wr_en = 1'b0; h_wdata = 16'hBEEF; h_bytesel = 2'b11; h_cs = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_b_bytesel", {28'b0, bif0.b_bytesel}, 32'h0);
    checkOutput("abort_b_addr", bif0.b_addr, 32'h0);
    checkOutput("abort_b_wdata", bif0.b_wdata, 32'h0);
    checkOutput("abort_h_rdata", {16'b0, bif0.h_rdata}, 32'h0);
    checkOutput("abort_h_compl", {31'b0, bif0.h_compl}, 32'h0);
    h_cs = 1'b0; h_bytesel = 2'b00; h_wdata = 16'h0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bus_lat = 2;
    applyStimulus(0, 32'h302, 1'b0, 16'h0000, 2'b11, 16'h1357, 3, 1'b1, 4'b1111);

    // Without the hold register every read goes to the bus with steered lanes.
    bus_data = 32'hAAAA5555;
    applyStimulus(1, 32'h100, 1'b0, 16'h0000, 2'b11, 16'h5555, 3, 1'b1, 4'b0011);
    applyStimulus(1, 32'h102, 1'b0, 16'h0000, 2'b11, 16'hAAAA, 3, 1'b1, 4'b1100);

    repeat (5) @(negedge clk);
    checkOutput("host_q_empty", host_q.size(), 32'h0);
    checkOutput("bus_q_empty", bus_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
